// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, shift-amount masking,
// valid/ready handshaking and write-back snooping while stalled.
module id_ex_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  input  logic [4:0]       rd_addr,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] pc,
  input  logic [1:0]       sel_a,
  input  logic             sel_b,
  input  logic [3:0]       alu_cntrl_in,
  input  logic             reg_write_in,
  input  logic             mem_fwd_we,
  input  logic [4:0]       mem_fwd_rd,
  input  logic [WIDTH-1:0] mem_fwd_data,
  input  logic             wb_fwd_we,
  input  logic [4:0]       wb_fwd_rd,
  input  logic [WIDTH-1:0] wb_fwd_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] src_a,
  output logic [WIDTH-1:0] src_b,
  output logic [3:0]       alu_cntrl,
  output logic [4:0]       rd_out,
  output logic             reg_write
);

  localparam logic [3:0] OP_MAX = 4'd9;

  function automatic logic [WIDTH-1:0] fwd_value(
    input logic [4:0]       addr,
    input logic [WIDTH-1:0] rf_data,
    input logic             m_we,
    input logic [4:0]       m_rd,
    input logic [WIDTH-1:0] m_data,
    input logic             w_we,
    input logic [4:0]       w_rd,
    input logic [WIDTH-1:0] w_data
  );
    logic [WIDTH-1:0] v;
    if (addr == 5'd0) begin
      v = '0;
    end else if (m_we && (m_rd == addr)) begin
      v = m_data;
    end else if (w_we && (w_rd == addr)) begin
      v = w_data;
    end else begin
      v = rf_data;
    end
    return v;
  endfunction

  function automatic logic is_shift(input logic [3:0] op);
    logic s;
    case (op)
      4'd4, 4'd8, 4'd9: s = 1'b1;
      default:          s = 1'b0;
    endcase
    return s;
  endfunction

  logic             r_valid;
  logic             r_reg_write;
  logic [WIDTH-1:0] r_src_a;
  logic [WIDTH-1:0] r_src_b;
  logic [3:0]       r_alu;
  logic [4:0]       r_rd;
  logic             r_a_from_rs;
  logic             r_b_from_rs;
  logic [4:0]       r_rs1_addr;
  logic [4:0]       r_rs2_addr;

  logic             w_in_ready;
  logic             w_capture;
  logic             w_hold;
  logic [WIDTH-1:0] w_rs1_fwd;
  logic [WIDTH-1:0] w_rs2_fwd;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_raw;
  logic [WIDTH-1:0] w_b_sel;
  logic             w_rw_in;
  logic             w_snoop_a;
  logic             w_snoop_b;

  logic             w_nxt_valid;
  logic             w_nxt_reg_write;
  logic [WIDTH-1:0] w_nxt_src_a;
  logic [WIDTH-1:0] w_nxt_src_b;
  logic [3:0]       w_nxt_alu;
  logic [4:0]       w_nxt_rd;
  logic             w_nxt_a_from_rs;
  logic             w_nxt_b_from_rs;
  logic [4:0]       w_nxt_rs1_addr;
  logic [4:0]       w_nxt_rs2_addr;

  assign w_in_ready = !r_valid || out_ready;
  assign w_capture  = in_valid && w_in_ready && !flush;
  assign w_hold     = r_valid && !out_ready;

  // Operand selection for the incoming instruction
  always_comb begin
    w_rs1_fwd = fwd_value(rs1_addr, rs1_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_we, wb_fwd_rd, wb_fwd_data);
    w_rs2_fwd = fwd_value(rs2_addr, rs2_data, mem_fwd_we, mem_fwd_rd, mem_fwd_data,
                          wb_fwd_we, wb_fwd_rd, wb_fwd_data);
    case (sel_a)
      2'd0:    w_a_sel = w_rs1_fwd;
      2'd1:    w_a_sel = pc;
      default: w_a_sel = '0;
    endcase
    if (sel_b) begin
      w_b_raw = imm;
    end else begin
      w_b_raw = w_rs2_fwd;
    end
    if (is_shift(alu_cntrl_in)) begin
      w_b_sel = {{(WIDTH-5){1'b0}}, w_b_raw[4:0]};
    end else begin
      w_b_sel = w_b_raw;
    end
    w_rw_in = reg_write_in && (alu_cntrl_in <= OP_MAX);
  end

  // Only the write-back port can refresh a stalled operand; MEM results are
  // older-in-flight and would already have been seen at capture time.
  assign w_snoop_a = w_hold && r_a_from_rs && (r_rs1_addr != 5'd0) &&
                     wb_fwd_we && (wb_fwd_rd == r_rs1_addr);
  assign w_snoop_b = w_hold && r_b_from_rs && (r_rs2_addr != 5'd0) &&
                     wb_fwd_we && (wb_fwd_rd == r_rs2_addr);

  // Next-state selection: flush, capture, drain, or hold with snoop
  always_comb begin
    w_nxt_valid     = r_valid;
    w_nxt_reg_write = r_reg_write;
    w_nxt_src_a     = r_src_a;
    w_nxt_src_b     = r_src_b;
    w_nxt_alu       = r_alu;
    w_nxt_rd        = r_rd;
    w_nxt_a_from_rs = r_a_from_rs;
    w_nxt_b_from_rs = r_b_from_rs;
    w_nxt_rs1_addr  = r_rs1_addr;
    w_nxt_rs2_addr  = r_rs2_addr;
    if (flush) begin
      w_nxt_valid     = 1'b0;
      w_nxt_reg_write = 1'b0;
    end else if (w_capture) begin
      w_nxt_valid     = 1'b1;
      w_nxt_reg_write = w_rw_in;
      w_nxt_src_a     = w_a_sel;
      w_nxt_src_b     = w_b_sel;
      w_nxt_alu       = alu_cntrl_in;
      w_nxt_rd        = rd_addr;
      w_nxt_a_from_rs = (sel_a == 2'd0);
      w_nxt_b_from_rs = !sel_b;
      w_nxt_rs1_addr  = rs1_addr;
      w_nxt_rs2_addr  = rs2_addr;
    end else if (r_valid && out_ready) begin
      w_nxt_valid     = 1'b0;
      w_nxt_reg_write = 1'b0;
    end else begin
      if (w_snoop_a) begin
        w_nxt_src_a = wb_fwd_data;
      end else begin
        w_nxt_src_a = r_src_a;
      end
      if (w_snoop_b) begin
        w_nxt_src_b = wb_fwd_data;
      end else begin
        w_nxt_src_b = r_src_b;
      end
    end
  end

  // Stage register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_src_a     <= '0;
      r_src_b     <= '0;
      r_alu       <= 4'd0;
      r_rd        <= 5'd0;
      r_a_from_rs <= 1'b0;
      r_b_from_rs <= 1'b0;
      r_rs1_addr  <= 5'd0;
      r_rs2_addr  <= 5'd0;
    end else begin
      r_valid     <= w_nxt_valid;
      r_reg_write <= w_nxt_reg_write;
      r_src_a     <= w_nxt_src_a;
      r_src_b     <= w_nxt_src_b;
      r_alu       <= w_nxt_alu;
      r_rd        <= w_nxt_rd;
      r_a_from_rs <= w_nxt_a_from_rs;
      r_b_from_rs <= w_nxt_b_from_rs;
      r_rs1_addr  <= w_nxt_rs1_addr;
      r_rs2_addr  <= w_nxt_rs2_addr;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_valid;
  assign reg_write = r_reg_write;
  assign src_a     = r_src_a;
  assign src_b     = r_src_b;
  assign alu_cntrl = r_alu;
  assign rd_out    = r_rd;

  id_ex_stage_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .in_ready  (w_in_ready),
    .out_valid (r_valid),
    .out_ready (out_ready),
    .reg_write (r_reg_write)
  );

endmodule

// Handshake invariants of the ID/EX stage.
module id_ex_stage_chk (
  input logic clk,
  input logic reset,
  input logic in_ready,
  input logic out_valid,
  input logic out_ready,
  input logic reg_write
);

  a_rw_needs_valid: assert property (@(posedge clk) disable iff (reset)
    reg_write |-> out_valid);

  a_in_ready_eq: assert property (@(posedge clk) disable iff (reset)
    in_ready == (!out_valid || out_ready));

endmodule

// File: tb/tb_id_ex_stage.sv
// Randomized and directed bench for id_ex_stage against a behavioural model.
module tb_id_ex_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic [1:0]  sel_a;
  logic        sel_b;
  logic [3:0]  alu_cntrl_in;
  logic        reg_write_in;
  logic        mem_fwd_we;
  logic [4:0]  mem_fwd_rd;
  logic [31:0] mem_fwd_data;
  logic        wb_fwd_we;
  logic [4:0]  wb_fwd_rd;
  logic [31:0] wb_fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] src_a, src_b;
  logic [3:0]  alu_cntrl;
  logic [4:0]  rd_out;
  logic        reg_write;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model of the instruction currently held by the stage
  bit          m_valid, m_rw, m_a_rs, m_b_rs;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  bit          n_valid, n_rw, n_a_rs, n_b_rs;
  logic [31:0] n_a, n_b;
  logic [3:0]  n_op;
  logic [4:0]  n_rd, n_rs1, n_rs2;

  id_ex_stage #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .sel_a(sel_a), .sel_b(sel_b), .alu_cntrl_in(alu_cntrl_in), .reg_write_in(reg_write_in),
    .mem_fwd_we(mem_fwd_we), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_we(wb_fwd_we), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .src_a(src_a), .src_b(src_b), .alu_cntrl(alu_cntrl), .rd_out(rd_out), .reg_write(reg_write)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 5'd0) return 32'd0;
    if (mem_fwd_we && mem_fwd_rd == addr) return mem_fwd_data;
    if (wb_fwd_we && wb_fwd_rd == addr) return wb_fwd_data;
    return rf;
  endfunction

  task automatic model_zero();
    m_valid = 1'b0; m_rw = 1'b0; m_a_rs = 1'b0; m_b_rs = 1'b0;
    m_a = 32'd0; m_b = 32'd0; m_op = 4'd0; m_rd = 5'd0; m_rs1 = 5'd0; m_rs2 = 5'd0;
  endtask

  task automatic model_next();
    bit rdy;
    rdy = !m_valid || out_ready;
    n_valid = m_valid; n_rw = m_rw; n_a_rs = m_a_rs; n_b_rs = m_b_rs;
    n_a = m_a; n_b = m_b; n_op = m_op; n_rd = m_rd; n_rs1 = m_rs1; n_rs2 = m_rs2;
    if (reset) begin
      n_valid = 1'b0; n_rw = 1'b0; n_a_rs = 1'b0; n_b_rs = 1'b0;
      n_a = 32'd0; n_b = 32'd0; n_op = 4'd0; n_rd = 5'd0; n_rs1 = 5'd0; n_rs2 = 5'd0;
    end else if (flush) begin
      n_valid = 1'b0; n_rw = 1'b0;
    end else if (in_valid && rdy) begin
      n_valid = 1'b1;
      n_op = alu_cntrl_in;
      n_rd = rd_addr;
      n_rw = reg_write_in && (alu_cntrl_in < 4'd10);
      n_a = (sel_a == 2'd0) ? m_fwd(rs1_addr, rs1_data) : (sel_a == 2'd1) ? pc : 32'd0;
      n_b = sel_b ? imm : m_fwd(rs2_addr, rs2_data);
      if (alu_cntrl_in == 4'd4 || alu_cntrl_in == 4'd8 || alu_cntrl_in == 4'd9)
        n_b = n_b & 32'h0000_001F;
      n_a_rs = (sel_a == 2'd0);
      n_b_rs = !sel_b;
      n_rs1 = rs1_addr;
      n_rs2 = rs2_addr;
    end else if (m_valid && out_ready) begin
      n_valid = 1'b0; n_rw = 1'b0;
    end else if (m_valid) begin
      if (wb_fwd_we && m_a_rs && m_rs1 != 5'd0 && wb_fwd_rd == m_rs1) n_a = wb_fwd_data;
      if (wb_fwd_we && m_b_rs && m_rs2 != 5'd0 && wb_fwd_rd == m_rs2) n_b = wb_fwd_data;
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    m_valid = n_valid; m_rw = n_rw; m_a_rs = n_a_rs; m_b_rs = n_b_rs;
    m_a = n_a; m_b = n_b; m_op = n_op; m_rd = n_rd; m_rs1 = n_rs1; m_rs2 = n_rs2;
    #2;
  endtask

  task automatic idle();
    in_valid = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0; rd_addr = 5'd0;
    rs1_data = 32'd0; rs2_data = 32'd0; imm = 32'd0; pc = 32'd0;
    sel_a = 2'd0; sel_b = 1'b0; alu_cntrl_in = 4'd0; reg_write_in = 1'b0;
    mem_fwd_we = 1'b0; mem_fwd_rd = 5'd0; mem_fwd_data = 32'd0;
    wb_fwd_we = 1'b0; wb_fwd_rd = 5'd0; wb_fwd_data = 32'd0;
    flush = 1'b0; out_ready = 1'b1;
  endtask

  task automatic async_reset();
    #1 reset = 1'b1;
    model_zero();
    #1;
    chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_async_rw", {31'd0, reg_write}, 32'd0);
    step();
    reset = 1'b0;
  endtask

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("reg_write", {31'd0, reg_write}, {31'd0, m_rw});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      if (m_valid || reset) begin
        chk("src_a", src_a, m_a);
        chk("src_b", src_b, m_b);
        chk("alu_cntrl", {28'd0, alu_cntrl}, {28'd0, m_op});
        chk("rd_out", {27'd0, rd_out}, {27'd0, m_rd});
      end
    end
  end

  initial begin
    idle();
    model_zero();
    reset = 1'b0;
    #1 reset = 1'b1;
    chk_en = 1'b1;
    step();
    step();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_src_a", src_a, 32'd0);
    chk("rst_src_b", src_b, 32'd0);
    chk("rst_rd", {27'd0, rd_out}, 32'd0);
    reset = 1'b0;

    // Forward priority: MEM beats WB beats register file
    in_valid = 1'b1; rs1_addr = 5'd5; rs1_data = 32'h33; sel_a = 2'd0;
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd5; mem_fwd_data = 32'h11;
    wb_fwd_we = 1'b1; wb_fwd_rd = 5'd5; wb_fwd_data = 32'h22;
    reg_write_in = 1'b1; rd_addr = 5'd3;
    step();
    chk("fwd_mem", src_a, 32'h11);
    chk("model_fwd_mem", m_a, 32'h11);
    chk("fwd_mem_valid", {31'd0, out_valid}, 32'd1);
    mem_fwd_we = 1'b0;
    step();
    chk("fwd_wb", src_a, 32'h22);

    // x0 always reads zero
    rs2_addr = 5'd0; rs2_data = 32'h55; sel_b = 1'b0;
    mem_fwd_we = 1'b1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hFFFF_FFFF;
    step();
    chk("x0_src_b", src_b, 32'd0);

    // Shift-amount masking
    idle(); in_valid = 1'b1; sel_b = 1'b1; imm = 32'h0000_0425; alu_cntrl_in = 4'd9;
    step();
    chk("shamt_mask", src_b, 32'h0000_0005);
    chk("model_shamt", m_b, 32'h0000_0005);
    alu_cntrl_in = 4'd0;
    step();
    chk("no_mask", src_b, 32'h0000_0425);
    alu_cntrl_in = 4'd12; reg_write_in = 1'b1;
    step();
    chk("bad_op_rw", {31'd0, reg_write}, 32'd0);
    chk("bad_op_code", {28'd0, alu_cntrl}, 32'd12);

    // Stall snoop: WB refreshes a held rs operand, MEM does not
    idle(); step();
    in_valid = 1'b1; out_ready = 1'b0; rs1_addr = 5'd7; rs1_data = 32'h77; sel_a = 2'd0;
    sel_b = 1'b1; imm = 32'h99; rd_addr = 5'd6; reg_write_in = 1'b1;
    step();
    chk("hold_src_a", src_a, 32'h77);
    in_valid = 1'b0; wb_fwd_we = 1'b1; wb_fwd_rd = 5'd7; wb_fwd_data = 32'hABCD;
    step();
    chk("snoop_wb", src_a, 32'hABCD);
    chk("snoop_imm_kept", src_b, 32'h99);
    wb_fwd_we = 1'b0; mem_fwd_we = 1'b1; mem_fwd_rd = 5'd7; mem_fwd_data = 32'h1234;
    step();
    chk("snoop_mem_ignored", src_a, 32'hABCD);

    // Flush while holding, with an incoming instruction
    mem_fwd_we = 1'b0; flush = 1'b1; in_valid = 1'b1; rd_addr = 5'd9;
    step();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_rw", {31'd0, reg_write}, 32'd0);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("flush_discard", {31'd0, out_valid}, 32'd0);

    // Back-to-back stream, then a reset mid-stream
    idle();
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; rd_addr = 5'(k); reg_write_in = 1'b1; rs1_addr = 5'(k); rs1_data = 32'(k * 16);
      step();
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_rd", {27'd0, rd_out}, 32'(k));
    end
    in_valid = 1'b0;
    step();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; rd_addr = 5'd10; out_ready = 1'b0;
    step();
    async_reset();
    chk("rst_midstream", {31'd0, out_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      out_ready    = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 15) == 0);
      rs1_addr     = 5'($urandom_range(0, 7));
      rs2_addr     = 5'($urandom_range(0, 7));
      rd_addr      = 5'($urandom_range(0, 31));
      rs1_data     = $urandom;
      rs2_data     = $urandom;
      imm          = $urandom;
      pc           = $urandom;
      sel_a        = 2'($urandom_range(0, 3));
      sel_b        = 1'($urandom_range(0, 1));
      alu_cntrl_in = 4'($urandom_range(0, 15));
      reg_write_in = 1'($urandom_range(0, 1));
      mem_fwd_we   = 1'($urandom_range(0, 1));
      mem_fwd_rd   = 5'($urandom_range(0, 7));
      mem_fwd_data = $urandom;
      wb_fwd_we    = 1'($urandom_range(0, 1));
      wb_fwd_rd    = 5'($urandom_range(0, 7));
      wb_fwd_data  = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        step();
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of operands and forwarding buses.
REQ-002 clk  in  1  rising-edge clock, the only clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1; in_ready  out  1: decode-side handshake.
REQ-005 rs1_addr, rs2_addr, rd_addr  in  5 each: source and destination register indices.
REQ-006 rs1_data, rs2_data, imm, pc  in  WIDTH each: register-file reads, sign-extended immediate, instruction PC.
REQ-007 sel_a  in  2: 0 = rs1, 1 = pc, 2 = zero, 3 = zero. sel_b  in  1: 0 = rs2, 1 = imm.
REQ-008 alu_cntrl_in  in  4 (ALU opcode 0-9); reg_write_in  in  1.
REQ-009 mem_fwd_we, mem_fwd_rd (5), mem_fwd_data (WIDTH)  in: EX/MEM result forward port.
REQ-010 wb_fwd_we, wb_fwd_rd (5), wb_fwd_data (WIDTH)  in: MEM/WB write-back forward port.
REQ-011 flush  in  1: kill the held and the incoming instruction.
REQ-012 out_valid  out  1; out_ready  in  1: ALU-side handshake.
REQ-013 src_a, src_b  out  WIDTH: ALU operands. alu_cntrl  out  4. rd_out  out  5. reg_write  out  1.

Function
REQ-014 Single register stage; in_ready = !out_valid || out_ready (combinational); capture occurs when in_valid && in_ready && !flush.
REQ-015 Latency is one cycle from capture to out_valid = 1; throughput is one instruction per cycle while out_ready = 1.
REQ-016 When out_valid && out_ready and no new capture occurs, out_valid clears on the next edge.
REQ-017 The stage holds all outputs stable while out_valid && !out_ready, except for the snoop refresh in REQ-022.
REQ-018 Forwarded rs value per source: if addr == 0, the value is 0. Else if mem_fwd_we && mem_fwd_rd == addr, use mem_fwd_data. Else if wb_fwd_we && wb_fwd_rd == addr, use wb_fwd_data. Else use rsN_data.
REQ-019 Captured src_a follows sel_a: forwarded rs1, pc, or 0. Captured src_b follows sel_b: forwarded rs2, or imm.
REQ-020 Shift masking: for alu_cntrl_in 4, 8 or 9, captured src_b = {zeros, selected_b[4:0]}. All other opcodes pass the value unchanged.
REQ-021 Opcodes above 9 are captured unchanged; reg_write is then forced to 0.
REQ-022 Snoop: while out_valid && !out_ready, each held operand is overwritten with wb_fwd_data on a wb_fwd_we match. This applies only if that operand was sourced from rs (sel), its held addr != 0, and the source is not immediate or pc. MEM-port matches are ignored while holding.
REQ-023 flush has priority: on the next edge out_valid = 0 and reg_write = 0, and any simultaneous capture is discarded. in_ready still follows REQ-014.
REQ-024 flush with out_valid = 0 and in_valid = 0 is a no-op.
REQ-025 Simultaneous drain and capture (out_valid && out_ready && in_valid) loads the new instruction with no bubble.
REQ-026 Data outputs are don't-care while out_valid = 0, but reg_write = 0 whenever out_valid = 0.

Reset
REQ-027 While reset is asserted, asynchronously: out_valid = 0, reg_write = 0, src_a = 0, src_b = 0, alu_cntrl = 0, rd_out = 0.
REQ-028 Reset asserted mid-hold drops the held instruction. The first capture is allowed on the first clk edge after deassertion.

Verification
REQ-029 Forward priority: rs1_addr = 5, mem_fwd (5, 0x11), wb_fwd (5, 0x22), rs1_data = 0x33, sel_a = 0 -> src_a = 0x11 next cycle. With mem_fwd_we = 0 -> src_a = 0x22.
REQ-030 x0: rs2_addr = 0, mem_fwd (0, 0xFFFF_FFFF), sel_b = 0 -> src_b = 0.
REQ-031 Shift mask: alu_cntrl_in = 9, sel_b = 1, imm = 0x0000_0425 -> src_b = 0x0000_0005. alu_cntrl_in = 0, same imm -> src_b = 0x0000_0425.
REQ-032 Stall snoop: hold rs1_addr = 7 with out_ready = 0, then pulse wb_fwd (7, 0xABCD) -> src_a = 0xABCD. A mem_fwd (7, 0x1234) while holding -> no change.
REQ-033 Flush: out_valid = 1, out_ready = 0, flush = 1 with in_valid = 1 -> out_valid = 0 and reg_write = 0 next cycle, and the incoming instruction never appears.
REQ-034 Back-to-back: 4 instructions with out_ready = 1 -> 4 consecutive out_valid cycles, in order, with no bubbles. Reset mid-stream -> out_valid = 0 immediately.
